// File: rtl/a_debouncer_pkg.sv
// Shared types and limits for the a_debouncer input-conditioning stage.
package a_debouncer_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } deb_state_t;

  // Legal range of the stability window.
  localparam int unsigned MIN_STABLE = 2;
  localparam int unsigned MAX_STABLE = 255;

  // Shallower chains do not give a metastable sample time to settle.
  localparam int unsigned MIN_SYNC_STAGES = 2;

  // Debounced level presented while sitting in a given state.
  function automatic logic level_of(input deb_state_t st);
    return (st == HIGH) || (st == CHK_LOW);
  endfunction

  // High while a candidate transition is being qualified.
  function automatic logic is_checking(input deb_state_t st);
    return (st == CHK_HIGH) || (st == CHK_LOW);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer bringing one asynchronous bit into the clk domain.
module bit_synchronizer
  import a_debouncer_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("bit_synchronizer: STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  // Shift the raw bit through the chain; stage 0 is the only one that can go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/a_debouncer.sv
// Synchronizes and debounces the raw control line feeding the sequence FSM's a input.
module a_debouncer
  import a_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic a,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

  if ((STABLE_CYCLES < MIN_STABLE) || (STABLE_CYCLES > MAX_STABLE)) begin : g_bad_stable
    $error("a_debouncer: STABLE_CYCLES must be in %0d..%0d", MIN_STABLE, MAX_STABLE);
  end

  logic             s;
  deb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             cnt_last;
  logic             a_n, rise_n, fall_n, busy_n;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (s)
  );

  // Candidate level has now been seen on STABLE_CYCLES consecutive samples.
  assign cnt_last = (cnt == CNT_W'(STABLE_CYCLES - 1));

  // State, counter and output registers; reset overrides any transition in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
      a     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      a     <= a_n;
      rise  <= rise_n;
      fall  <= fall_n;
      busy  <= busy_n;
    end
  end

  // Next state, counter and registered-output values.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rise_n  = 1'b0;
    fall_n  = 1'b0;

    unique case (state)
      LOW: begin
        if (s) begin
          state_n = CHK_HIGH;
          cnt_n   = CNT_W'(1);
        end
      end
      CHK_HIGH: begin
        if (!s) begin
          state_n = LOW;
          cnt_n   = '0;
        end else if (cnt_last) begin
          state_n = HIGH;
          cnt_n   = '0;
          rise_n  = 1'b1;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_n = CHK_LOW;
          cnt_n   = CNT_W'(1);
        end
      end
      CHK_LOW: begin
        if (s) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt_last) begin
          state_n = LOW;
          cnt_n   = '0;
          fall_n  = 1'b1;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = LOW;
        cnt_n   = '0;
      end
    endcase

    a_n    = level_of(state_n);
    busy_n = is_checking(state_n);
  end

endmodule
